// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings and default width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/fa.sv
// One-bit full adder cell, used as the serial arithmetic bit slice.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor d = a - b, LSB first, one bit per clock (start/done handshake).
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;
  logic   load, shift, last;

  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    count;
  logic             carry, diff, carry_next;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // DONE accepts a new start just like IDLE, giving back-to-back operation.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    last       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (count == LAST) begin
          last       = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_SHIFT;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    busy = (state == S_SHIFT);
    done = (state == S_DONE);
  end

  // Subtraction as a + ~b + 1: the initial carry of 1 supplies the +1.
  fa u_fa (
    .a    (sa[0]),
    .b    (~sb[0]),
    .cin  (carry),
    .s    (diff),
    .cout (carry_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      d     <= '0;
      carry <= 1'b0;
      count <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      sa    <= a;
      sb    <= b;
      carry <= 1'b1;
      count <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
`endif
    end else if (shift) begin
      carry <= carry_next;
      d     <= {diff, d[WIDTH-1:1]};
      sa    <= {1'b0, sa[WIDTH-1:1]};
      sb    <= {1'b0, sb[WIDTH-1:1]};
      count <= count + 1'b1;
      // The final carry is "no borrow"; diff here becomes the result MSB.
      if (last) begin
        bout <= ~carry_next;
`ifdef SERIAL_SUB_OVF_EN
        ovf  <= (a_msb != b_msb) && (diff != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=4): vector table plus multi-cycle corner sequences.
module tb_serial_sub;

  localparam int WIDTH = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy, done, bout;
  logic [WIDTH-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_d;
    logic             exp_bout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[9];

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
  task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               output int busy_cycles, output logic got_done);
    a     = va;
    b     = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   bc;
    int   gap;
    logic gd;

    vecs[0] = '{4'd7,  4'd3,  4'd4,  1'b0, 1'b0};
    vecs[1] = '{4'd3,  4'd7,  4'd12, 1'b1, 1'b0};
    vecs[2] = '{4'd15, 4'd15, 4'd0,  1'b0, 1'b0};
    vecs[3] = '{4'd0,  4'd1,  4'd15, 1'b1, 1'b0};
    vecs[4] = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b1};
    vecs[5] = '{4'd5,  4'd2,  4'd3,  1'b0, 1'b0};
    vecs[6] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
    vecs[7] = '{4'd9,  4'd12, 4'd13, 1'b1, 1'b0};
    vecs[8] = '{4'd7,  4'd8,  4'd15, 1'b1, 1'b1};

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset d",    d,    0);
    checkOutput("reset bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset ovf",  ovf,  0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, bc, gd);
      checkOutput($sformatf("vec%0d done seen", i), gd, 1);
      checkOutput($sformatf("vec%0d busy cycles", i), bc, WIDTH);
      checkOutput($sformatf("vec%0d d", i), d, vecs[i].exp_d);
      checkOutput($sformatf("vec%0d bout", i), bout, vecs[i].exp_bout);
`ifdef SERIAL_SUB_OVF_EN
      checkOutput($sformatf("vec%0d ovf", i), ovf, vecs[i].exp_ovf);
`endif
      @(negedge clk);
      checkOutput($sformatf("vec%0d done width", i), done, 0);
      checkOutput($sformatf("vec%0d d held", i), d, vecs[i].exp_d);
    end

    // start held through SHIFT with changed operands must not disturb the op.
    a = 4'd7; b = 4'd3; start = 1'b1;
    @(negedge clk);
    a = 4'd1; b = 4'd9;
    gd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        gd = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("held start done", gd, 1);
    checkOutput("held start d", d, 4);
    checkOutput("held start bout", bout, 0);
    @(negedge clk);
    checkOutput("held start idle busy", busy, 0);
    checkOutput("held start idle done", done, 0);

    // Back-to-back: start in the DONE cycle, second done 5 cycles later.
    applyStimulus(4'd7, 4'd3, bc, gd);
    checkOutput("b2b first done", gd, 1);
    checkOutput("b2b first d", d, 4);
    a = 4'd3; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b reload busy", busy, 1);
    gap = 1;
    gd  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        gd = 1'b1;
        break;
      end
      gap++;
      @(negedge clk);
    end
    checkOutput("b2b second done", gd, 1);
    checkOutput("b2b gap", gap, 5);
    checkOutput("b2b second d", d, 12);
    checkOutput("b2b second bout", bout, 1);
    @(negedge clk);

    // Reset during the second SHIFT cycle aborts immediately.
    a = 4'd7; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset d",    d,    0);
    checkOutput("midreset bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("midreset ovf",  ovf,  0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midreset no done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(4'd5, 4'd2, bc, gd);
    checkOutput("post reset done", gd, 1);
    checkOutput("post reset busy cycles", bc, WIDTH);
    checkOutput("post reset d", d, 3);
    checkOutput("post reset bout", bout, 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
